// File: rtl/axi_pkg.sv
// Shared AXI4 encodings, master FSM state type and beat-size helper
// used by the cache-side AXI burst master.
package axi_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_DONE    = 3'd5
  } state_t;

  // AxSIZE encoding for a full-width beat.
  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/axi_beat_ctr.sv
// Beat index and count tracker shared by the R and W data paths: idx walks
// the line modulo LINE_WORDS from start_idx, last flags the final beat.
module axi_beat_ctr #(
  parameter int LINE_WORDS = 4,
  parameter int IDX_W      = $clog2(LINE_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] start_idx,
  input  logic [IDX_W-1:0] final_cnt,
  input  logic             inc,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] final_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      cnt     <= '0;
      final_q <= '0;
    end else if (load) begin
      idx     <= start_idx;
      cnt     <= '0;
      final_q <= final_cnt;
    end else if (inc) begin
      idx <= idx + 1'b1;
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == final_q);

endmodule

// File: rtl/axi_burst_master.sv
// AXI4 master for a cache controller: single-beat uncached accesses and
// full-line fills/write-backs, one transaction outstanding at a time.
module axi_burst_master #(
  parameter int ID_W       = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int WRAP_EN    = 0,
  parameter int ID_VAL     = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_i,
  input  logic                         write_i,
  input  logic                         line_i,
  input  logic [ADDR_W-1:0]            addr_i,
  input  logic [DATA_W/8-1:0]          wstrb_i,
  input  logic [LINE_WORDS*DATA_W-1:0] wdata_i,
  output logic [LINE_WORDS*DATA_W-1:0] rdata_o,
  output logic                         wait_o,
  output logic                         done_o,
  output logic                         err_o,
  output logic [ID_W-1:0]              m_awid,
  output logic [ADDR_W-1:0]            m_awaddr,
  output logic [7:0]                   m_awlen,
  output logic [2:0]                   m_awsize,
  output logic [1:0]                   m_awburst,
  output logic                         m_awvalid,
  input  logic                         m_awready,
  output logic [DATA_W-1:0]            m_wdata,
  output logic [DATA_W/8-1:0]          m_wstrb,
  output logic                         m_wlast,
  output logic                         m_wvalid,
  input  logic                         m_wready,
  input  logic [ID_W-1:0]              m_bid,
  input  logic [1:0]                   m_bresp,
  input  logic                         m_bvalid,
  output logic                         m_bready,
  output logic [ID_W-1:0]              m_arid,
  output logic [ADDR_W-1:0]            m_araddr,
  output logic [7:0]                   m_arlen,
  output logic [2:0]                   m_arsize,
  output logic [1:0]                   m_arburst,
  output logic                         m_arvalid,
  input  logic                         m_arready,
  input  logic [ID_W-1:0]              m_rid,
  input  logic [DATA_W-1:0]            m_rdata,
  input  logic [1:0]                   m_rresp,
  input  logic                         m_rlast,
  input  logic                         m_rvalid,
  output logic                         m_rready
);
  import axi_pkg::*;

  localparam int BYTES      = DATA_W / 8;
  localparam int OFF_W      = $clog2(BYTES);
  localparam int IDX_W      = $clog2(LINE_WORDS);
  localparam int LINE_OFF_W = OFF_W + IDX_W;

  state_t                      state_q, state_d;
  logic                        line_q, aw_done_q, w_done_q, err_q;
  logic [ADDR_W-1:0]           addr_q;
  logic [1:0]                  burst_q;
  logic [BYTES-1:0]            wstrb_q;
  logic [LINE_WORDS*DATA_W-1:0] wdata_q, rdata_q;

  logic             accept, use_wrap, aw_hs, w_hs, r_hs, b_hs, ctr_last;
  logic [IDX_W-1:0] ctr_idx;
  logic [ADDR_W-1:0] word_addr, line_addr;

  assign accept    = (state_q == ST_IDLE) && req_i;
  assign use_wrap  = line_i && !write_i && (WRAP_EN != 0);
  assign word_addr = {addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign line_addr = {addr_i[ADDR_W-1:LINE_OFF_W], {LINE_OFF_W{1'b0}}};
  assign aw_hs     = m_awvalid && m_awready;
  assign w_hs      = m_wvalid && m_wready;
  assign r_hs      = m_rvalid && m_rready;
  assign b_hs      = m_bvalid && m_bready;

  // One counter serves whichever data channel the current transaction uses.
  axi_beat_ctr #(.LINE_WORDS(LINE_WORDS)) u_beat_ctr (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .start_idx (use_wrap ? addr_i[LINE_OFF_W-1:OFF_W] : IDX_W'(0)),
    .final_cnt (line_i ? IDX_W'(LINE_WORDS - 1) : IDX_W'(0)),
    .inc       (r_hs || w_hs),
    .idx       (ctr_idx),
    .last      (ctr_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (req_i) state_d = write_i ? ST_WR : ST_RD_ADDR;
      ST_RD_ADDR: if (m_arready) state_d = ST_RD_DATA;
      ST_RD_DATA: if (r_hs && ctr_last) state_d = ST_DONE;
      ST_WR:      if ((aw_done_q || aw_hs) && (w_done_q || (w_hs && ctr_last)))
                    state_d = ST_WR_RESP;
      ST_WR_RESP: if (m_bvalid) state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    m_arvalid = (state_q == ST_RD_ADDR);
    m_rready  = (state_q == ST_RD_DATA);
    m_awvalid = (state_q == ST_WR) && !aw_done_q;
    m_wvalid  = (state_q == ST_WR) && !w_done_q;
    m_bready  = (state_q == ST_WR_RESP);
    done_o    = (state_q == ST_DONE);
    wait_o    = accept || (state_q inside {ST_RD_ADDR, ST_RD_DATA, ST_WR, ST_WR_RESP});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      line_q    <= 1'b0;
      addr_q    <= '0;
      burst_q   <= BURST_INCR;
      wstrb_q   <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
      rdata_q   <= '0;
    end else if (accept) begin
      line_q    <= line_i;
      addr_q    <= (line_i && !use_wrap) ? line_addr : word_addr;
      burst_q   <= use_wrap ? BURST_WRAP : BURST_INCR;
      wstrb_q   <= wstrb_i;
      wdata_q   <= wdata_i;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (aw_hs)             aw_done_q <= 1'b1;
      if (w_hs && ctr_last)  w_done_q  <= 1'b1;
      if (r_hs) begin
        rdata_q[ctr_idx*DATA_W +: DATA_W] <= m_rdata;
        // rlast must coincide exactly with the counted final beat.
        if ((m_rresp != RESP_OKAY) || (m_rlast != ctr_last)) err_q <= 1'b1;
      end
      if (b_hs && (m_bresp != RESP_OKAY)) err_q <= 1'b1;
    end
  end

  assign rdata_o   = rdata_q;
  assign err_o     = err_q;

  assign m_awid    = ID_W'(ID_VAL);
  assign m_awaddr  = addr_q;
  assign m_awlen   = line_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign m_awsize  = axi_size(DATA_W);
  assign m_awburst = BURST_INCR;
  assign m_wdata   = wdata_q[ctr_idx*DATA_W +: DATA_W];
  assign m_wstrb   = line_q ? {BYTES{1'b1}} : wstrb_q;
  assign m_wlast   = m_wvalid && ctr_last;

  assign m_arid    = ID_W'(ID_VAL);
  assign m_araddr  = addr_q;
  assign m_arlen   = line_q ? 8'(LINE_WORDS - 1) : 8'd0;
  assign m_arsize  = axi_size(DATA_W);
  assign m_arburst = burst_q;

  logic unused_inputs;
  assign unused_inputs = ^{m_bid, m_rid, addr_i[OFF_W-1:0]};

endmodule

// File: tb/tb_axi_burst_master.sv
// Bench for axi_burst_master: one INCR instance and one WRAP instance, each
// driven by a per-cycle AXI slave model and checked against an address/data model.
module tb_axi_burst_master;
  localparam int LW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst[2], req[2], write[2], line[2];
  logic [31:0]  addr[2];
  logic [3:0]   wstrb[2];
  logic [127:0] wdata[2];
  logic         awready[2], wready[2], bvalid[2], arready[2], rvalid[2], rlast[2];
  logic [1:0]   bresp[2], rresp[2];
  logic [31:0]  rd[2];
  logic [3:0]   bid[2], rid[2];

  wire [127:0] rdata[2];
  wire         wait_s[2], done[2], err[2];
  wire [3:0]   awid[2], arid[2];
  wire [31:0]  awaddr[2], araddr[2], wd[2];
  wire [7:0]   awlen[2], arlen[2];
  wire [2:0]   awsize[2], arsize[2];
  wire [1:0]   awburst[2], arburst[2];
  wire [3:0]   ws[2];
  wire         awvalid[2], wvalid[2], wlast[2], bready[2], arvalid[2], rready[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axi_burst_master #(.LINE_WORDS(LW), .WRAP_EN(g)) u_dut (
      .clk(clk), .rst(rst[g]), .req_i(req[g]), .write_i(write[g]), .line_i(line[g]),
      .addr_i(addr[g]), .wstrb_i(wstrb[g]), .wdata_i(wdata[g]), .rdata_o(rdata[g]),
      .wait_o(wait_s[g]), .done_o(done[g]), .err_o(err[g]),
      .m_awid(awid[g]), .m_awaddr(awaddr[g]), .m_awlen(awlen[g]), .m_awsize(awsize[g]),
      .m_awburst(awburst[g]), .m_awvalid(awvalid[g]), .m_awready(awready[g]),
      .m_wdata(wd[g]), .m_wstrb(ws[g]), .m_wlast(wlast[g]), .m_wvalid(wvalid[g]),
      .m_wready(wready[g]), .m_bid(bid[g]), .m_bresp(bresp[g]), .m_bvalid(bvalid[g]),
      .m_bready(bready[g]), .m_arid(arid[g]), .m_araddr(araddr[g]), .m_arlen(arlen[g]),
      .m_arsize(arsize[g]), .m_arburst(arburst[g]), .m_arvalid(arvalid[g]),
      .m_arready(arready[g]), .m_rid(rid[g]), .m_rdata(rd[g]), .m_rresp(rresp[g]),
      .m_rlast(rlast[g]), .m_rvalid(rvalid[g]), .m_rready(rready[g])
    );
  end

  int n_total = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave stimulus and per-transaction observations.
  logic [31:0]  r_beats[LW];
  logic [127:0] model_rdata[2];
  int           o_done_cnt, o_done_cyc, o_w_n, o_aw_cyc, o_wlast_cyc, o_r_n;
  logic         o_err, o_wait_req, o_wait_done, o_early_b, o_stall_bad;
  logic [127:0] o_rdata;
  logic [31:0]  o_ax_addr, o_w_data[16];
  logic [7:0]   o_ax_len;
  logic [2:0]   o_ax_size;
  logic [1:0]   o_ax_burst;
  logic [3:0]   o_w_strb[16];
  logic         o_w_last[16];
  logic         o_rr_before, o_rr_after, o_wait_after, o_arv_after;
  logic [127:0] o_rdata_after;

  task automatic run_txn(input int d, input bit wr, input bit ln, input logic [31:0] a,
                         input logic [3:0] strb, input logic [127:0] wdv, input int aw_delay,
                         input int wmode, input int err_beat, input int bad_last, input int rst_beat);
    int nb, k, aw_wait, wc;
    bit ar_seen, aw_seen, wl_seen, b_sent, stall_pend, stall_last;
    logic [31:0] stall_data;
    nb = ln ? LW : 1; k = 0; aw_wait = 0; wc = 0;
    ar_seen = 0; aw_seen = 0; wl_seen = 0; b_sent = 0; stall_pend = 0;
    stall_last = 0; stall_data = '0;
    o_done_cnt = 0; o_done_cyc = 0; o_w_n = 0; o_aw_cyc = -1; o_wlast_cyc = -1;
    o_early_b = 0; o_stall_bad = 0; o_err = 1'bx; o_rdata = 'x; o_wait_done = 1'bx;
    o_ax_addr = 'x; o_ax_len = 'x; o_ax_size = 'x; o_ax_burst = 'x;
    @(negedge clk);
    req[d] = 1; write[d] = wr; line[d] = ln; addr[d] = a; wstrb[d] = strb; wdata[d] = wdv;
    #1 o_wait_req = wait_s[d];
    for (int c = 1; c <= 200; c++) begin
      @(negedge clk);
      req[d] = 0;
      if (done[d]) begin
        if (o_done_cnt == 0) begin
          o_done_cyc = c; o_err = err[d]; o_rdata = rdata[d]; o_wait_done = wait_s[d];
        end
        o_done_cnt++;
      end
      if (o_done_cnt > 0 && c >= o_done_cyc + 2) break;
      if (rst_beat >= 0 && k == rst_beat + 1) begin
        o_rr_before = rready[d];
        rvalid[d] = 0; rst[d] = 1;
        #1;
        o_rr_after = rready[d]; o_wait_after = wait_s[d];
        o_rdata_after = rdata[d]; o_arv_after = arvalid[d];
        model_rdata[d] = '0;
        o_r_n = k;
        return;
      end
      // B only after both the AW and final W handshakes have happened.
      if (bready[d] && !(aw_seen && wl_seen)) o_early_b = 1;
      bvalid[d] = 0;
      if (!b_sent && aw_seen && wl_seen) begin
        bvalid[d] = 1; bresp[d] = 2'b00;
        if (bready[d]) b_sent = 1;
      end
      rvalid[d] = 0;
      if (ar_seen && k < nb) begin
        rvalid[d] = 1; rd[d] = r_beats[k];
        rresp[d] = (k == err_beat) ? 2'b10 : 2'b00;
        rlast[d] = (k == nb - 1) ^ (k == bad_last);
        if (rready[d]) k++;
      end
      arready[d] = 1;
      if (arvalid[d] && !ar_seen) begin
        ar_seen = 1;
        o_ax_addr = araddr[d]; o_ax_len = arlen[d]; o_ax_size = arsize[d]; o_ax_burst = arburst[d];
      end
      awready[d] = awvalid[d] && (aw_wait >= aw_delay);
      if (awvalid[d]) begin
        if (awready[d]) begin
          aw_seen = 1; o_aw_cyc = c;
          o_ax_addr = awaddr[d]; o_ax_len = awlen[d]; o_ax_size = awsize[d]; o_ax_burst = awburst[d];
        end else aw_wait++;
      end
      if (wvalid[d]) begin
        if (stall_pend && (wd[d] !== stall_data || wlast[d] !== stall_last)) o_stall_bad = 1;
        wready[d] = (wmode == 0) ? 1'b1 : (wmode == 1) ? wc[0] : 1'($urandom_range(0, 1));
        wc++;
        stall_pend = !wready[d]; stall_data = wd[d]; stall_last = wlast[d];
        if (wready[d] && o_w_n < 16) begin
          o_w_data[o_w_n] = wd[d]; o_w_strb[o_w_n] = ws[d]; o_w_last[o_w_n] = wlast[d];
          o_w_n++;
          if (wlast[d]) begin wl_seen = 1; o_wlast_cyc = c; end
        end
      end else wready[d] = 0;
    end
    o_r_n = k;
    rvalid[d] = 0; bvalid[d] = 0; arready[d] = 0; awready[d] = 0; wready[d] = 0;
  endtask

  // Reference model: addressing rules and where each read beat lands.
  function automatic logic [31:0] exp_addr(input int d, input bit wr, input bit ln, input logic [31:0] a);
    if (ln && !(d == 1 && !wr)) return a & ~32'hF;
    return a & ~32'h3;
  endfunction

  function automatic logic [1:0] exp_burst(input int d, input bit wr, input bit ln);
    return (ln && d == 1 && !wr) ? 2'b10 : 2'b01;
  endfunction

  task automatic model_read(input int d, input bit ln, input logic [31:0] a);
    int st, nb;
    nb = ln ? LW : 1;
    st = (ln && d == 1) ? int'(a[3:2]) : 0;
    for (int k = 0; k < nb; k++) model_rdata[d][((st + k) % LW) * 32 +: 32] = r_beats[k];
  endtask

  task automatic check_common(input string t, input int d, input bit wr, input bit ln, input logic [31:0] a);
    check({t, "_done_pulses"}, 128'(o_done_cnt), 128'd1);
    check({t, "_addr"}, o_ax_addr, exp_addr(d, wr, ln, a));
    check({t, "_len"}, o_ax_len, ln ? 128'(LW - 1) : 128'd0);
    check({t, "_burst"}, o_ax_burst, exp_burst(d, wr, ln));
    check({t, "_size"}, o_ax_size, 128'd2);
    check({t, "_wait_in_done"}, o_wait_done, 128'd0);
  endtask

  task automatic check_writes(input string t, input bit ln, input logic [3:0] strb, input logic [127:0] wdv);
    int nb;
    nb = ln ? LW : 1;
    check({t, "_w_beats"}, 128'(o_w_n), 128'(nb));
    for (int k = 0; k < nb; k++) begin
      check($sformatf("%s_wdata%0d", t, k), o_w_data[k], wdv[k*32 +: 32]);
      check($sformatf("%s_wstrb%0d", t, k), o_w_strb[k], ln ? 128'hF : 128'(strb));
      check($sformatf("%s_wlast%0d", t, k), o_w_last[k], 128'(k == nb - 1));
    end
    check({t, "_early_bready"}, o_early_b, 128'd0);
  endtask

  initial begin
    logic [127:0] wdv;
    logic [31:0]  a;
    logic [3:0]   strb;
    int           d;
    bit           wr, ln;

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1; req[i] = 0; write[i] = 0; line[i] = 0; addr[i] = 0; wstrb[i] = 0; wdata[i] = 0;
      awready[i] = 0; wready[i] = 0; bvalid[i] = 0; bresp[i] = 0; bid[i] = 0;
      arready[i] = 0; rvalid[i] = 0; rlast[i] = 0; rresp[i] = 0; rd[i] = 0; rid[i] = 0;
      model_rdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset_ctrl%0d", i),
            {arvalid[i], awvalid[i], wvalid[i], bready[i], rready[i], wait_s[i], done[i], err[i]}, 128'd0);
      check($sformatf("reset_rdata%0d", i), rdata[i], 128'd0);
    end
    rst[0] = 0; rst[1] = 0;

    // Line read, INCR
    r_beats = '{32'h11, 32'h22, 32'h33, 32'h44};
    run_txn(0, 0, 1, 32'h1234, 4'h0, '0, 0, 0, -1, -1, -1);
    model_read(0, 1, 32'h1234);
    check_common("t1", 0, 0, 1, 32'h1234);
    check("t1_rdata", o_rdata, 128'h00000044_00000033_00000022_00000011);
    check("t1_err", o_err, 128'd0);
    check("t1_latency", 128'(o_done_cyc), 128'(LW + 2));
    check("t1_wait_at_req", o_wait_req, 128'd1);

    // Critical-word-first WRAP read
    r_beats = '{32'hA, 32'hB, 32'hC, 32'hD};
    run_txn(1, 0, 1, 32'h1238, 4'h0, '0, 0, 0, -1, -1, -1);
    model_read(1, 1, 32'h1238);
    check_common("t2", 1, 0, 1, 32'h1238);
    check("t2_rdata", o_rdata, model_rdata[1]);
    check("t2_rdata_lit", o_rdata, 128'h0000000B_0000000A_0000000D_0000000C);

    // Single write, AW delayed: W completes first
    wdv = {96'h0, 32'hDEADBEEF};
    run_txn(0, 1, 0, 32'h2002, 4'b1100, wdv, 3, 0, -1, -1, -1);
    check_common("t3", 0, 1, 0, 32'h2002);
    check_writes("t3", 0, 4'b1100, wdv);
    check("t3_w_before_aw", 128'(o_wlast_cyc < o_aw_cyc), 128'd1);
    check("t3_err", o_err, 128'd0);

    // Line write with alternating wready
    wdv = {32'h44440004, 32'h33330003, 32'h22220002, 32'h11110001};
    run_txn(0, 1, 1, 32'h3018, 4'h0, wdv, 0, 1, -1, -1, -1);
    check_common("t4", 0, 1, 1, 32'h3018);
    check_writes("t4", 1, 4'h0, wdv);
    check("t4_stall_stable", o_stall_bad, 128'd0);

    // SLVERR on beat 2, then a clean read clears err
    r_beats = '{32'h5, 32'h6, 32'h7, 32'h8};
    run_txn(0, 0, 1, 32'h4000, 4'h0, '0, 0, 0, 2, -1, -1);
    model_read(0, 1, 32'h4000);
    check("t5_beats", 128'(o_r_n), 128'(LW));
    check("t5_err", o_err, 128'd1);
    check("t5_rdata", o_rdata, model_rdata[0]);
    r_beats = '{32'h99, 32'h0, 32'h0, 32'h0};
    run_txn(0, 0, 0, 32'h4006, 4'h0, '0, 0, 0, -1, -1, -1);
    model_read(0, 0, 32'h4006);
    check_common("t5b", 0, 0, 0, 32'h4006);
    check("t5b_err", o_err, 128'd0);
    check("t5b_rdata", o_rdata, model_rdata[0]);

    // Early rlast on beat 1
    r_beats = '{32'h1, 32'h2, 32'h3, 32'h4};
    run_txn(1, 0, 1, 32'h5004, 4'h0, '0, 0, 0, -1, 1, -1);
    model_read(1, 1, 32'h5004);
    check("t5c_err", o_err, 128'd1);
    check("t5c_rdata", o_rdata, model_rdata[1]);

    // Reset pulsed during RD_DATA after beat 1
    r_beats = '{32'hF1, 32'hF2, 32'hF3, 32'hF4};
    run_txn(0, 0, 1, 32'h6000, 4'h0, '0, 0, 0, -1, -1, 1);
    check("t6_rready_before", o_rr_before, 128'd1);
    check("t6_rready_after", o_rr_after, 128'd0);
    check("t6_wait_after", o_wait_after, 128'd0);
    check("t6_arvalid_after", o_arv_after, 128'd0);
    check("t6_rdata_after", o_rdata_after, 128'd0);
    @(negedge clk);
    rst[0] = 0;
    r_beats = '{32'hE1, 32'hE2, 32'hE3, 32'hE4};
    run_txn(0, 0, 1, 32'h6010, 4'h0, '0, 0, 0, -1, -1, -1);
    model_read(0, 1, 32'h6010);
    check_common("t6b", 0, 0, 1, 32'h6010);
    check("t6b_rdata", o_rdata, model_rdata[0]);
    check("t6b_err", o_err, 128'd0);

    // Randomized mix against the model
    for (int t = 0; t < 10; t++) begin
      d = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      ln = 1'($urandom_range(0, 1));
      a = $urandom & 32'h0000_FFFF;
      strb = 4'($urandom_range(1, 15));
      wdv = {$urandom, $urandom, $urandom, $urandom};
      for (int k = 0; k < LW; k++) r_beats[k] = $urandom;
      run_txn(d, wr, ln, a, strb, wdv, int'($urandom_range(0, 2)), 2, -1, -1, -1);
      check_common($sformatf("rnd%0d", t), d, wr, ln, a);
      check($sformatf("rnd%0d_err", t), o_err, 128'd0);
      if (wr) check_writes($sformatf("rnd%0d", t), ln, strb, wdv);
      else begin
        model_read(d, ln, a);
        check($sformatf("rnd%0d_rdata", t), o_rdata, model_rdata[d]);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
